dht11_emulator: RTL and testbench

Single-wire DHT11 sensor emulator: the responder side of the DHT11 protocol that our DHT11 host reader initiates. The emulator detects the host start pulse on the open-drain data line. It then answers with the 80 µs/80 µs acknowledge and a 40-bit frame built from register inputs plus a computed checksum. It serves as a loopback target for on-board and simulation testing of the reader without a physical sensor.

---
 rtl/dht11_emulator_if.sv | 38 +++
 rtl/dht11_emulator.sv | 200 ++++++++++++++++++++
 tb/tb_dht11_emulator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dht11_emulator_if.sv
// rtl/dht11_emulator_if.sv - signal bundle between a DHT11 host/bench and the emulator
//
// Purpose: groups the emulator's control, pad and payload signals so one port carries them.
// Signals:
//    EN          host side -> emulator   enables start detection
//    DATA_IN     host side -> emulator   sampled bus level (asynchronous pad input)
//    HUM_INT     host side -> emulator   payload byte 0 (sent first)
//    HUM_FLOAT   host side -> emulator   payload byte 1
//    TEMP_INT    host side -> emulator   payload byte 2
//    TEMP_FLOAT  host side -> emulator   payload byte 3
//    CRC_CORRUPT host side -> emulator   invert checksum bit0 at snapshot
//    DATA_LOW    emulator -> host side   1 = pull bus low, 0 = release
//    BUSY        emulator -> host side   frame in progress
//    DONE        emulator -> host side   one-cycle frame-complete pulse
// Modports: master = stimulus/host side, slave = emulator.

interface dht11_emulator_if;
   logic       EN;
   logic       DATA_IN;
   logic [7:0] HUM_INT;
   logic [7:0] HUM_FLOAT;
   logic [7:0] TEMP_INT;
   logic [7:0] TEMP_FLOAT;
   logic       CRC_CORRUPT;
   logic       DATA_LOW;
   logic       BUSY;
   logic       DONE;

   modport master (
      output EN, DATA_IN, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC_CORRUPT,
      input  DATA_LOW, BUSY, DONE
   );

   modport slave (
      input  EN, DATA_IN, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC_CORRUPT,
      output DATA_LOW, BUSY, DONE
   );
endinterface

// File: rtl/dht11_emulator.sv
// rtl/dht11_emulator.sv - DHT11 single-wire sensor emulator (responder side)
//
// Purpose: detects the host start pulse on the open-drain data line, answers with the
// acknowledge and a 40-bit frame {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CKS}, MSB first.
// Ports:
//    CLK     in   clock (parameters are cycle counts at 100 MHz)
//    RST     in   synchronous, active-high reset
//    io_dht  slave modport of dht11_emulator_if (EN, DATA_IN, payload, CRC_CORRUPT in;
//            DATA_LOW, BUSY, DONE out; all outputs registered)

module dht11_emulator #(
   parameter int START_MIN  = 100000,
   parameter int RESP_DELAY = 3000,
   parameter int ACK_LOW    = 8000,
   parameter int ACK_HIGH   = 8000,
   parameter int BIT_LOW    = 5000,
   parameter int ZERO_HIGH  = 2600,
   parameter int ONE_HIGH   = 7000
) (
   input  logic            CLK,
   input  logic            RST,
   dht11_emulator_if.slave io_dht
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOST_LOW,
      S_RESP_WAIT,
      S_ACK_LOW,
      S_ACK_HIGH,
      S_BIT_LOW,
      S_BIT_HIGH,
      S_EOT_LOW
   } state_t;

   // Timed states leave when the counter (cleared on entry) reaches duration-1,
   // so each state, and therefore each DATA_LOW level, lasts exactly its count.
   localparam logic [19:0] C_START_MIN = 20'(START_MIN);
   localparam logic [19:0] C_RESP_LAST = 20'(RESP_DELAY - 1);
   localparam logic [19:0] C_ACKL_LAST = 20'(ACK_LOW - 1);
   localparam logic [19:0] C_ACKH_LAST = 20'(ACK_HIGH - 1);
   localparam logic [19:0] C_BITL_LAST = 20'(BIT_LOW - 1);
   localparam logic [19:0] C_ZERO_LAST = 20'(ZERO_HIGH - 1);
   localparam logic [19:0] C_ONE_LAST  = 20'(ONE_HIGH - 1);

   state_t      r_state;
   logic        r_sync1;
   logic        r_din_s;
   logic [19:0] r_cnt;
   logic [5:0]  r_idx;
   logic [39:0] r_shift;
   logic        r_data_low;
   logic        r_busy;
   logic        r_done;

   state_t      w_state_nxt;
   logic [19:0] w_cnt_nxt;
   logic [5:0]  w_idx_nxt;
   logic [39:0] w_shift_nxt;
   logic        w_done_nxt;
   logic        w_data_low_nxt;
   logic        w_busy_nxt;
   logic [19:0] w_high_last;
   logic [7:0]  w_sum;
   logic [7:0]  w_cks;

   // 8-bit wrap-around sum; carry discarded by the result width.
   assign w_sum = io_dht.HUM_INT + io_dht.HUM_FLOAT + io_dht.TEMP_INT + io_dht.TEMP_FLOAT;
   assign w_cks = w_sum ^ {7'd0, io_dht.CRC_CORRUPT};

   assign w_high_last = r_shift[39] ? C_ONE_LAST : C_ZERO_LAST;

   // Synchronizer resets to the idle (pulled-up) level so reset never looks like a start.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= 1'b1;
         r_din_s <= 1'b1;
      end else begin
         r_sync1 <= io_dht.DATA_IN;
         r_din_s <= r_sync1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_data_low <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_data_low <= w_data_low_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 20'd1;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (io_dht.EN && !r_din_s) begin
               w_state_nxt = S_HOST_LOW;
               w_cnt_nxt   = 20'd1;
            end
         end

         S_HOST_LOW: begin
            if (!io_dht.EN) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_din_s) begin
               w_cnt_nxt = '0;
               if (r_cnt >= C_START_MIN) begin
                  w_state_nxt = S_RESP_WAIT;
                  w_shift_nxt = {io_dht.HUM_INT, io_dht.HUM_FLOAT,
                                 io_dht.TEMP_INT, io_dht.TEMP_FLOAT, w_cks};
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (r_cnt >= C_START_MIN) begin
               w_cnt_nxt = r_cnt;
            end
         end

         S_RESP_WAIT: begin
            if (r_cnt == C_RESP_LAST) begin
               w_state_nxt = S_ACK_LOW;
               w_cnt_nxt   = '0;
            end
         end

         S_ACK_LOW: begin
            if (r_cnt == C_ACKL_LAST) begin
               w_state_nxt = S_ACK_HIGH;
               w_cnt_nxt   = '0;
            end
         end

         S_ACK_HIGH: begin
            if (r_cnt == C_ACKH_LAST) begin
               w_state_nxt = S_BIT_LOW;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         end

         S_BIT_LOW: begin
            if (r_cnt == C_BITL_LAST) begin
               w_state_nxt = S_BIT_HIGH;
               w_cnt_nxt   = '0;
            end
         end

         S_BIT_HIGH: begin
            if (r_cnt == w_high_last) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {r_shift[38:0], 1'b0};
               w_idx_nxt   = r_idx + 6'd1;
               w_state_nxt = (r_idx == 6'd39) ? S_EOT_LOW : S_BIT_LOW;
            end
         end

         S_EOT_LOW: begin
            if (r_cnt == C_BITL_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Outputs are registered from the next state so DATA_LOW edges coincide with state changes.
      w_data_low_nxt = (w_state_nxt == S_ACK_LOW) || (w_state_nxt == S_BIT_LOW) ||
                       (w_state_nxt == S_EOT_LOW);
      w_busy_nxt     = (w_state_nxt != S_IDLE) && (w_state_nxt != S_HOST_LOW);
   end

   assign io_dht.DATA_LOW = r_data_low;
   assign io_dht.BUSY     = r_busy;
   assign io_dht.DONE     = r_done;

endmodule

// File: tb/tb_dht11_emulator.sv
// tb/tb_dht11_emulator.sv - self-checking bench for dht11_emulator

module tb_dht11_emulator;

   localparam int SM = 40;
   localparam int RD = 6;
   localparam int AL = 10;
   localparam int AH = 12;
   localparam int BL = 5;
   localparam int ZH = 3;
   localparam int OH = 8;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic r_host_low = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int hi_len [40];

   dht11_emulator_if bus ();

   // Open-drain bus: either side pulling low wins, pull-up otherwise.
   assign bus.DATA_IN = ~(r_host_low | bus.DATA_LOW);

   dht11_emulator #(
      .START_MIN (SM),
      .RESP_DELAY(RD),
      .ACK_LOW   (AL),
      .ACK_HIGH  (AH),
      .BIT_LOW   (BL),
      .ZERO_HIGH (ZH),
      .ONE_HIGH  (OH)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .io_dht(bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (bus.DONE) done_cnt <= done_cnt + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic wait_dl(input logic lvl, input int maxc, output int n);
      n = 0;
      do begin
         @(posedge CLK);
         #1;
         n++;
      end while (bus.DATA_LOW !== lvl && n <= maxc);
   endtask

   task automatic host_start(input int low_cycles);
      @(negedge CLK);
      r_host_low = 1'b1;
      repeat (low_cycles) @(negedge CLK);
      r_host_low = 1'b0;
   endtask

   task automatic watch_quiet(input int cyc, output bit seen);
      seen = 1'b0;
      repeat (cyc) begin
         @(posedge CLK);
         #1;
         if (bus.DATA_LOW || bus.BUSY) seen = 1'b1;
      end
   endtask

   task automatic set_payload(input logic [7:0] h, input logic [7:0] hf, input logic [7:0] t,
                              input logic [7:0] tf, input logic c);
      bus.HUM_INT     = h;
      bus.HUM_FLOAT   = hf;
      bus.TEMP_INT    = t;
      bus.TEMP_FLOAT  = tf;
      bus.CRC_CORRUPT = c;
   endtask

   // Decodes one frame from DATA_LOW; mut_bit zeroes the payload during that bit,
   // rst_bit pulses RST during that bit's low preamble and abandons the frame.
   task automatic decode_frame(input string tag, input int mut_bit, input int rst_bit,
                               output logic [39:0] frame, output bit aborted);
      int n;
      int errs;
      logic b;
      frame   = '0;
      aborted = 1'b0;
      errs    = 0;
      wait_dl(1'b1, 300, n);
      check({tag, "_resp_latency"}, n, RD + 3);
      wait_dl(1'b0, 100, n);
      check({tag, "_ack_low"}, n, AL);
      wait_dl(1'b1, 100, n);
      check({tag, "_ack_high"}, n, AH);
      for (int i = 0; i < 40; i++) begin
         if (i == rst_bit) begin
            @(negedge CLK);
            RST = 1'b1;
            @(posedge CLK);
            #1;
            check({tag, "_rst_release"}, bus.DATA_LOW, 1'b0);
            check({tag, "_rst_busy"}, bus.BUSY, 1'b0);
            @(negedge CLK);
            RST = 1'b0;
            aborted = 1'b1;
            return;
         end
         wait_dl(1'b0, 50, n);
         if (n != BL) errs++;
         if (i == mut_bit) set_payload(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
         wait_dl(1'b1, 50, n);
         hi_len[i] = n;
         b = (n > (ZH + OH) / 2);
         if (n != (b ? OH : ZH)) errs++;
         frame = {frame[38:0], b};
      end
      check({tag, "_bit_timing_errs"}, errs, 0);
      wait_dl(1'b0, 50, n);
      check({tag, "_eot_low"}, n, BL);
      check({tag, "_done_pulse"}, bus.DONE, 1'b1);
      check({tag, "_busy_fall"}, bus.BUSY, 1'b0);
      @(posedge CLK);
      #1;
      check({tag, "_done_clear"}, bus.DONE, 1'b0);
   endtask

   task automatic run_frame(input string tag, input logic [39:0] exp_frame,
                            input int mut_bit, input int rst_bit);
      logic [39:0] frame;
      bit aborted;
      int d0;
      d0 = done_cnt;
      host_start(60);
      decode_frame(tag, mut_bit, rst_bit, frame, aborted);
      if (aborted) begin
         repeat (40) @(posedge CLK);
         #1;
         check({tag, "_no_done"}, done_cnt - d0, 0);
      end else begin
         check({tag, "_frame"}, frame, exp_frame);
         check({tag, "_done_once"}, done_cnt - d0, 1);
      end
      repeat (10) @(posedge CLK);
   endtask

   initial begin
      bit seen;
      bus.EN = 1'b1;
      set_payload(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
      repeat (3) @(posedge CLK);
      #1;
      check("reset_data_low", bus.DATA_LOW, 1'b0);
      check("reset_busy", bus.BUSY, 1'b0);
      check("reset_done", bus.DONE, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (5) @(posedge CLK);

      // 0x37+0x00+0x19+0x05 = 0x55
      run_frame("basic", 40'h37_00_19_05_55, -1, -1);
      check("basic_bit0_high", hi_len[0], ZH);
      check("basic_bit2_high", hi_len[2], OH);

      // One cycle short of the minimum host low: rejected.
      host_start(SM - 1);
      watch_quiet(80, seen);
      check("glitch_reject", seen, 1'b0);

      // Start detection disabled.
      bus.EN = 1'b0;
      host_start(60);
      watch_quiet(80, seen);
      check("en_low_ignore", seen, 1'b0);
      bus.EN = 1'b1;
      repeat (5) @(posedge CLK);

      // Exactly the minimum host low is accepted; 4*0xFF wraps to 0xFC.
      set_payload(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      begin
         logic [39:0] f;
         bit ab;
         host_start(SM);
         decode_frame("min_low_ff", -1, -1, f, ab);
         check("min_low_ff_frame", f, 40'hFF_FF_FF_FF_FC);
         repeat (10) @(posedge CLK);
      end

      set_payload(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
      run_frame("ff_corrupt", 40'hFF_FF_FF_FF_FD, -1, -1);

      // 0xAA+0x55+0x0F+0xF0 = 0x1FE -> 0xFE; inputs zeroed during bit 10.
      set_payload(8'hAA, 8'h55, 8'h0F, 8'hF0, 1'b0);
      run_frame("snapshot", 40'hAA_55_0F_F0_FE, 10, -1);

      // Reset during bit 20 preamble, then a clean frame.
      set_payload(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
      run_frame("rst_mid", 40'h0, -1, 20);
      run_frame("after_rst", 40'h37_00_19_05_55, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
